rotary_quad_sequencer: RTL and testbench

Self-test stimulus controller for the rotary-encoder decoder. On command it drives a programmable number of quadrature edges on `rt_a`/`rt_b` in a chosen direction at a programmable rate. This replaces the free-running counter-derived test pattern with a deterministic, handshaked sequence. It sits between the top-level I/O and the decoder's A/B inputs, muxed in when test mode is enabled, and keeps a reference position count that the bench compares against the decoder's count.

---
 rtl/rotary_pkg.sv | 36 +++
 rtl/rotary_tick_gen.sv | 43 ++++
 rtl/rotary_quad_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rotary_quad_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// rotary_pkg
// Shared definitions for the rotary-encoder test stimulus sequencer:
// FSM state type, 2-bit (A,B) phase encodings, direction constants and the
// quadrature phase-advance helper.
package rotary_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Phase encodings are {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_CCW = 1'b0;
  localparam logic DIR_CW  = 1'b1;

  // One quadrature step; exactly one of A/B toggles.
  // CW: 00->10->11->01->00, CCW is the reverse.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = (dir == DIR_CW) ? PH_10 : PH_01;
      PH_10:   nxt = (dir == DIR_CW) ? PH_11 : PH_00;
      PH_11:   nxt = (dir == DIR_CW) ? PH_01 : PH_10;
      PH_01:   nxt = (dir == DIR_CW) ? PH_00 : PH_11;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rotary_tick_gen.sv
// rotary_tick_gen
// Loadable down-counter prescaler. tick_o is high whenever the count is 0.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (count -> 0)
//   load_i     load load_val_i (has priority over en_i)
//   en_i       decrement by one (saturates at 0)
//   load_val_i reload value
//   tick_o     count == 0
module rotary_tick_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/rotary_quad_sequencer.sv
// rotary_quad_sequencer
// Self-test stimulus controller for the rotary-encoder decoder. On a start
// command it emits `steps` quadrature edges on rt_a/rt_b in direction `dir`,
// holding each A/B state period+1 cycles, and tracks a reference position.
// Ports:
//   clk_in, reset_n         clock, asynchronous active-low reset
//   start, dir, steps,      run command (sampled in IDLE only)
//   period
//   abort                   terminate a run in progress
//   rt_a, rt_b              registered quadrature outputs
//   busy                    run active
//   done                    one-cycle pulse at completion / abort / zero-step start
//   aborted                 last run ended by abort
//   edges_left              remaining edges in the current run
//   pos                     reference position (+1 CW edge, -1 CCW edge)
module rotary_quad_sequencer
  import rotary_pkg::*;
#(
  parameter int unsigned STEPS_W  = 8,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned POS_W    = 8
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                start,
  input  logic                dir,
  input  logic [STEPS_W-1:0]  steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic                rt_a,
  output logic                rt_b,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STEPS_W-1:0]  edges_left,
  output logic [POS_W-1:0]    pos
);

  seq_state_e          state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic                dir_q, dir_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [STEPS_W-1:0]  edges_q, edges_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                tick;
  logic                pre_load;
  logic                pre_en;
  logic [PERIOD_W-1:0] pre_val;
  logic                last_edge;

  assign last_edge = (edges_q == STEPS_W'(1));

  rotary_tick_gen #(
    .WIDTH (PERIOD_W)
  ) u_tick_gen (
    .clk_i      (clk_in),
    .rst_ni     (reset_n),
    .load_i     (pre_load),
    .en_i       (pre_en),
    .load_val_i (pre_val),
    .tick_o     (tick)
  );

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over a coincident tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (steps != '0)) state_d = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick && last_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: command latch, phase, edge counter, position
  always_comb begin
    phase_d   = phase_q;
    dir_d     = dir_q;
    period_d  = period_q;
    edges_d   = edges_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    pre_load  = 1'b0;
    pre_en    = 1'b0;
    pre_val   = period_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (steps != '0) begin
            dir_d     = dir;
            period_d  = period;
            edges_d   = steps;
            aborted_d = 1'b0;
            pre_load  = 1'b1;
            pre_val   = period;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (tick) begin
          phase_d  = phase_step(phase_q, dir_q);
          edges_d  = edges_q - STEPS_W'(1);
          pos_d    = (dir_q == DIR_CW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          pre_load = 1'b1;
          done_d   = last_edge;
        end else begin
          pre_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_00;
      dir_q     <= DIR_CCW;
      period_q  <= '0;
      edges_q   <= '0;
      pos_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      period_q  <= period_d;
      edges_q   <= edges_d;
      pos_q     <= pos_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Outputs
  always_comb begin
    rt_a       = phase_q[1];
    rt_b       = phase_q[0];
    busy       = (state_q == ST_RUN);
    done       = done_q;
    aborted    = aborted_q;
    edges_left = edges_q;
    pos        = pos_q;
  end

endmodule

// File: tb/tb_rotary_quad_sequencer.sv
module tb_rotary_quad_sequencer;

  logic       clk_in  = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       dir     = 1'b0;
  logic       abort   = 1'b0;
  logic [7:0] steps   = '0;
  logic [7:0] period  = '0;
  logic       rt_a, rt_b, busy, done, aborted;
  logic [7:0] edges_left, pos;

  rotary_quad_sequencer #(
    .STEPS_W  (8),
    .PERIOD_W (8),
    .POS_W    (8)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .start      (start),
    .dir        (dir),
    .steps      (steps),
    .period     (period),
    .abort      (abort),
    .rt_a       (rt_a),
    .rt_b       (rt_b),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .edges_left (edges_left),
    .pos        (pos)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int gcyc     = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk_in) gcyc <= gcyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] ab;
    logic [7:0] pos;
    logic [7:0] left;
  } exp_t;

  exp_t       sb[$];
  bit         exp_done [4096];
  bit         exp_busy [4096];
  logic [1:0] m_ab    = 2'b00;
  logic [7:0] m_pos   = 8'd0;
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] obs_ab;
  exp_t       mon_e;

  // Scoreboard consumer: per-cycle done/busy, and every A/B change popped
  always @(negedge clk_in) begin
    obs_ab = {rt_a, rt_b};
    if (mon_en && gcyc < 4096) begin
      n_checks++;
      if (done !== exp_done[gcyc]) begin
        n_fail++;
        $display("FAIL done_pulse: cycle %0d done=%b expected %b", gcyc, done, exp_done[gcyc]);
      end
      n_checks++;
      if (busy !== exp_busy[gcyc]) begin
        n_fail++;
        $display("FAIL busy_level: cycle %0d busy=%b expected %b", gcyc, busy, exp_busy[gcyc]);
      end
      if (obs_ab !== prev_ab) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_edge: cycle %0d ab=%b prev=%b expected no change", gcyc, obs_ab, prev_ab);
        end else begin
          mon_e = sb.pop_front();
          n_checks++;
          if (gcyc !== mon_e.cyc) begin
            n_fail++;
            $display("FAIL edge_cycle: edge at cycle %0d expected %0d", gcyc, mon_e.cyc);
          end
          n_checks++;
          if (obs_ab !== mon_e.ab) begin
            n_fail++;
            $display("FAIL edge_ab: cycle %0d ab=%b expected %b", gcyc, obs_ab, mon_e.ab);
          end
          n_checks++;
          if (pos !== mon_e.pos) begin
            n_fail++;
            $display("FAIL edge_pos: cycle %0d pos=%0d expected %0d", gcyc, pos, mon_e.pos);
          end
          n_checks++;
          if (edges_left !== mon_e.left) begin
            n_fail++;
            $display("FAIL edge_left: cycle %0d edges_left=%0d expected %0d", gcyc, edges_left, mon_e.left);
          end
        end
      end
    end
    prev_ab = obs_ab;
  end

  // Reference quadrature ring, walked forward for CW and backward for CCW
  function automatic logic [1:0] step_ab(input logic [1:0] ab, input logic d);
    logic [1:0] ring [4];
    int idx;
    ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;
    idx = 0;
    for (int i = 0; i < 4; i++) if (ring[i] == ab) idx = i;
    return d ? ring[(idx + 1) % 4] : ring[(idx + 3) % 4];
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 4096; i++) begin
      exp_done[i] = 1'b0;
      exp_busy[i] = 1'b0;
    end
  endtask

  // Relative cycle k after the accepting edge is sampled when gcyc == e0+k-1.
  // Edge k of a run appears at relative cycle 1+k*(p+1).
  task automatic push_run(input logic d, input int n, input int p, input int e0, input int abort_k);
    exp_t e;
    int   rel;
    int   endrel;
    for (int k = 1; k <= n; k++) begin
      rel = 1 + k * (p + 1);
      if (abort_k != 0 && rel > abort_k) break;
      m_ab   = step_ab(m_ab, d);
      m_pos  = d ? m_pos + 8'd1 : m_pos - 8'd1;
      e.cyc  = e0 + rel - 1;
      e.ab   = m_ab;
      e.pos  = m_pos;
      e.left = 8'(n - k);
      sb.push_back(e);
    end
    endrel = (abort_k != 0) ? abort_k : n * (p + 1);
    for (int r = 1; r <= endrel; r++) exp_busy[e0 + r - 1] = 1'b1;
    exp_done[e0 + endrel] = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    @(negedge clk_in);
    while (gcyc < target) @(negedge clk_in);
  endtask

  // Called at a negedge; returns #1 after the accepting edge
  task automatic issue_start(input logic d, input int n, input int p, output int e0);
    start  = 1'b1;
    dir    = d;
    steps  = 8'(n);
    period = 8'(p);
    @(posedge clk_in);
    #1;
    start  = 1'b0;
    dir    = ~d;
    steps  = 8'($urandom);
    period = 8'($urandom);
    e0     = gcyc;
  endtask

  task automatic expect_drained(input string tag);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d edges still pending, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    sb.delete();
    clear_exp();
    m_ab  = 2'b00;
    m_pos = 8'd0;
    @(negedge clk_in);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_in);
    n_checks++; if ({rt_a, rt_b} !== 2'b00) begin n_fail++; $display("FAIL reset_ab: got %b expected 00", {rt_a, rt_b}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b expected 0", aborted); end
    n_checks++; if (edges_left !== 8'd0) begin n_fail++; $display("FAIL reset_left: got %0d expected 0", edges_left); end
    n_checks++; if (pos !== 8'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", pos); end
    reset_n = 1'b1;
    clear_exp();
    @(negedge clk_in);
    mon_en = 1'b1;
  endtask

  task automatic test_cw_basic();
    int e0;
    wait_cyc(0);
    issue_start(1'b1, 4, 2, e0);
    push_run(1'b1, 4, 2, e0, 0);
    wait_cyc(e0 + 14);
    expect_drained("cw_basic");
    n_checks++; if (pos !== 8'd4) begin n_fail++; $display("FAIL cw_pos_final: got %0d expected 4", pos); end
  endtask

  task automatic test_ccw_wrap();
    int e0;
    do_reset();
    wait_cyc(0);
    issue_start(1'b0, 3, 0, e0);
    push_run(1'b0, 3, 0, e0, 0);
    wait_cyc(e0 + 4);
    expect_drained("ccw_wrap");
    n_checks++; if (pos !== 8'd253) begin n_fail++; $display("FAIL ccw_pos_wrap: got %0d expected 253", pos); end
    issue_start(1'b1, 1, 0, e0);
    push_run(1'b1, 1, 0, e0, 0);
    wait_cyc(e0 + 3);
    expect_drained("cw_after_ccw");
    n_checks++; if ({rt_a, rt_b} !== 2'b11) begin n_fail++; $display("FAIL cw_after_ccw_ab: got %b expected 11", {rt_a, rt_b}); end
  endtask

  task automatic test_abort(input int abort_k);
    int e0;
    wait_cyc(0);
    issue_start(1'b1, 10, 5, e0);
    push_run(1'b1, 10, 5, e0, abort_k);
    wait_cyc(e0 + abort_k - 1);
    abort = 1'b1;
    @(posedge clk_in);
    #1 abort = 1'b0;
    wait_cyc(e0 + abort_k);
    n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL abort_flag_k%0d: got %b expected 1", abort_k, aborted); end
    n_checks++; if (edges_left !== 8'd7) begin n_fail++; $display("FAIL abort_left_k%0d: got %0d expected 7", abort_k, edges_left); end
    wait_cyc(e0 + abort_k + 4);
    n_checks++; if (edges_left !== 8'd7) begin n_fail++; $display("FAIL abort_left_frozen_k%0d: got %0d expected 7", abort_k, edges_left); end
    expect_drained("abort");
    issue_start(1'b1, 1, 0, e0);
    n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL abort_cleared_k%0d: got %b expected 0", abort_k, aborted); end
    push_run(1'b1, 1, 0, e0, 0);
    wait_cyc(e0 + 3);
    expect_drained("after_abort");
  endtask

  task automatic test_zero_steps();
    int         e0;
    logic [1:0] ab0;
    logic [7:0] left0;
    wait_cyc(0);
    ab0   = {rt_a, rt_b};
    left0 = edges_left;
    issue_start(1'b1, 0, 3, e0);
    push_run(1'b1, 0, 3, e0, 0);
    wait_cyc(e0 + 4);
    n_checks++; if ({rt_a, rt_b} !== ab0) begin n_fail++; $display("FAIL zero_ab: got %b expected %b", {rt_a, rt_b}, ab0); end
    n_checks++; if (edges_left !== left0) begin n_fail++; $display("FAIL zero_left: got %0d expected %0d", edges_left, left0); end
    expect_drained("zero_steps");
  endtask

  task automatic test_busy_ignored();
    int e0;
    wait_cyc(0);
    issue_start(1'b1, 3, 3, e0);
    push_run(1'b1, 3, 3, e0, 0);
    for (int k = 0; k < 2; k++) begin
      wait_cyc(e0 + 2 + 5 * k);
      start = 1'b1; steps = 8'd200; dir = 1'b0; period = 8'd0;
      @(posedge clk_in);
      #1 start = 1'b0;
    end
    wait_cyc(e0 + 14);
    expect_drained("busy_ignored");
    n_checks++; if (edges_left !== 8'd0) begin n_fail++; $display("FAIL busy_ignored_left: got %0d expected 0", edges_left); end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    wait_cyc(0);
    issue_start(1'b0, 2, 1, e0a);
    push_run(1'b0, 2, 1, e0a, 0);
    wait_cyc(e0a + 4);
    issue_start(1'b1, 3, 0, e0b);
    push_run(1'b1, 3, 0, e0b, 0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_cyc(e0b + 5);
    expect_drained("back_to_back");
  endtask

  task automatic test_reset_midrun();
    int e0;
    wait_cyc(0);
    issue_start(1'b1, 5, 3, e0);
    push_run(1'b1, 5, 3, e0, 0);
    wait_cyc(e0 + 6);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({rt_a, rt_b} !== 2'b00) begin n_fail++; $display("FAIL async_rst_ab: got %b expected 00", {rt_a, rt_b}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    n_checks++; if (pos !== 8'd0) begin n_fail++; $display("FAIL async_rst_pos: got %0d expected 0", pos); end
    n_checks++; if (edges_left !== 8'd0) begin n_fail++; $display("FAIL async_rst_left: got %0d expected 0", edges_left); end
    sb.delete();
    clear_exp();
    m_ab  = 2'b00;
    m_pos = 8'd0;
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    n_checks++; if ({rt_a, rt_b} !== 2'b00 || pos !== 8'd0) begin n_fail++; $display("FAIL post_rst_state: ab=%b pos=%0d expected ab=00 pos=0", {rt_a, rt_b}, pos); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL post_rst_done: got %b expected 0", done); end
    mon_en = 1'b1;
    wait_cyc(0);
    issue_start(1'b1, 2, 0, e0);
    push_run(1'b1, 2, 0, e0, 0);
    wait_cyc(e0 + 4);
    expect_drained("post_reset_run");
  endtask

  initial begin
    clear_exp();
    test_reset();
    test_cw_basic();
    test_ccw_wrap();
    test_abort(20);
    test_abort(24);
    test_zero_steps();
    test_busy_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
